// File: rtl/dancer_sprite_renderer_pkg.sv
// dancer_pkg: shared sprite geometry, key color, sprite indices, priority order and screen limits.
package dancer_pkg;
  localparam int SPR_W = 32;
  localparam int SPR_H = 64;
  localparam int COLOR_W = 16;
  localparam logic [15:0] KEY_COLOR = 16'hF81F;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  typedef enum logic [1:0] {SPR_D0 = 2'd0, SPR_D1 = 2'd1, SPR_D2 = 2'd2, SPR_BRUCE = 2'd3} spr_e;
  localparam spr_e PRIO [4] = '{SPR_BRUCE, SPR_D0, SPR_D1, SPR_D2};
endpackage

// File: rtl/dancer_sprite_renderer_if.sv
// dancer_sprite_renderer_if: scan, position, ROM and pixel signals between the motion/VGA side and the renderer.
interface dancer_sprite_renderer_if #(parameter int COLOR_W = 16, parameter int ROM_AW = 13);
  logic [9:0] iVGA_X;
  logic [8:0] iVGA_Y;
  logic iVGA_req;
  logic [3:0] dancer_en;
  logic [9:0] id0_x, id1_x, id2_x, ibruce_x;
  logic [8:0] id0_y, id1_y, id2_y, ibruce_y;
  logic [COLOR_W-1:0] iBg_color;
  logic [ROM_AW-1:0] oRom_addr;
  logic [COLOR_W-1:0] iRom_data;
  logic [COLOR_W-1:0] oPix_color;
  logic oPix_valid;
  logic oFrame_latch;
  logic oCollision;
  modport master (
    output iVGA_X, iVGA_Y, iVGA_req, dancer_en, id0_x, id1_x, id2_x, ibruce_x,
           id0_y, id1_y, id2_y, ibruce_y, iBg_color, iRom_data,
    input  oRom_addr, oPix_color, oPix_valid, oFrame_latch, oCollision
  );
  modport slave (
    input  iVGA_X, iVGA_Y, iVGA_req, dancer_en, id0_x, id1_x, id2_x, ibruce_x,
           id0_y, id1_y, id2_y, ibruce_y, iBg_color, iRom_data,
    output oRom_addr, oPix_color, oPix_valid, oFrame_latch, oCollision
  );
endinterface

// File: rtl/dancer_sprite_renderer_hit_test.sv
// sprite_hit_test: per-sprite coverage test and in-sprite offset; clipped at the screen edge, never wrapped.
module sprite_hit_test import dancer_pkg::*; #(
  parameter int SPR_W = 32,
  parameter int SPR_H = 64,
  localparam int DXW = $clog2(SPR_W),
  localparam int DYW = $clog2(SPR_H)
) (
  input  logic [9:0] vga_x,
  input  logic [8:0] vga_y,
  input  logic [9:0] pos_x,
  input  logic [8:0] pos_y,
  input  logic en,
  output logic hit,
  output logic [DXW-1:0] dx,
  output logic [DYW-1:0] dy
);
  logic [10:0] ddx;
  logic [9:0] ddy;
  assign ddx = {1'b0, vga_x} - {1'b0, pos_x};
  assign ddy = {1'b0, vga_y} - {1'b0, pos_y};
  assign hit = en && !ddx[10] && ddx[9:0] < 10'(SPR_W) && !ddy[9] && ddy[8:0] < 9'(SPR_H)
               && vga_x < 10'(SCR_W) && vga_y < 9'(SCR_H);
  assign dx = ddx[DXW-1:0];
  assign dy = ddy[DYW-1:0];
endmodule

// File: rtl/dancer_sprite_renderer.sv
// dancer_sprite_renderer: 2-stage sprite pixel pipeline with per-frame shadow positions.
// Optional COLLISION_EN builds the sticky overlap detector driving oCollision.
module dancer_sprite_renderer import dancer_pkg::*; #(
  parameter int SPR_W = dancer_pkg::SPR_W,
  parameter int SPR_H = dancer_pkg::SPR_H,
  parameter int COLOR_W = dancer_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] KEY_COLOR = dancer_pkg::KEY_COLOR
) (
  input logic clk,
  input logic reset_n,
  dancer_sprite_renderer_if.slave bus
);
  localparam int DXW = $clog2(SPR_W);
  localparam int DYW = $clog2(SPR_H);
  logic [3:0][9:0] sx;
  logic [3:0][8:0] sy;
  logic [3:0] sen, hit;
  logic [3:0][DXW-1:0] dx;
  logic [3:0][DYW-1:0] dy;
  logic armed, at_org, latch, fire, hit1, v1;
  logic [COLOR_W-1:0] bg1;
  spr_e sel;
  assign at_org = bus.iVGA_X == 10'd0 && bus.iVGA_Y == 9'd0;
  assign latch = at_org && armed;
  // armed drops after the first (0,0) cycle so a held origin latches only once
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sx <= '0;
      sy <= '0;
      sen <= '0;
      armed <= 1'b1;
      fire <= 1'b0;
    end else begin
      armed <= !at_org;
      fire <= latch;
      if (latch) begin
        sx <= {bus.ibruce_x, bus.id2_x, bus.id1_x, bus.id0_x};
        sy <= {bus.ibruce_y, bus.id2_y, bus.id1_y, bus.id0_y};
        sen <= bus.dancer_en;
      end
    end
  assign bus.oFrame_latch = fire;
  for (genvar i = 0; i < 4; i++) begin : g_hit
    sprite_hit_test #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
      .vga_x(bus.iVGA_X), .vga_y(bus.iVGA_Y), .pos_x(sx[i]), .pos_y(sy[i]),
      .en(sen[i]), .hit(hit[i]), .dx(dx[i]), .dy(dy[i])
    );
  end
  always_comb begin
    sel = SPR_BRUCE;
    for (int i = 3; i >= 0; i--) if (hit[PRIO[i]]) sel = PRIO[i];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.oRom_addr <= '0;
      hit1 <= 1'b0;
      bg1 <= '0;
      v1 <= 1'b0;
      bus.oPix_color <= '0;
      bus.oPix_valid <= 1'b0;
    end else begin
      bus.oRom_addr <= |hit ? {sel, dy[sel], dx[sel]} : '0;
      hit1 <= |hit;
      bg1 <= bus.iBg_color;
      v1 <= bus.iVGA_req;
      bus.oPix_color <= v1 ? ((hit1 && bus.iRom_data != KEY_COLOR) ? bus.iRom_data : bg1) : '0;
      bus.oPix_valid <= v1;
    end
`ifdef COLLISION_EN
  logic multi, sticky, coll;
  assign multi = bus.iVGA_req && (hit & (hit - 4'd1)) != 4'd0;
  // the origin pixel already belongs to the new frame, so it seeds the fresh sticky flag
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sticky <= 1'b0;
      coll <= 1'b0;
    end else if (latch) begin
      coll <= sticky;
      sticky <= multi;
    end else begin
      sticky <= sticky | multi;
    end
  assign bus.oCollision = coll;
`else
  assign bus.oCollision = 1'b0;
`endif
endmodule

// File: tb/tb_dancer_sprite_renderer.sv
// tb_dancer_sprite_renderer: directed vectors with hand-computed ROM addresses and pixel colors.
module tb_dancer_sprite_renderer;
  import dancer_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic key_mode = 1'b0;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_pulses = 0;
  localparam logic [15:0] BG = 16'h1234;
  always #5 clk = ~clk;
  dancer_sprite_renderer_if ifc ();
  dancer_sprite_renderer dut (.clk(clk), .reset_n(reset_n), .bus(ifc));
  assign ifc.iRom_data = key_mode ? KEY_COLOR : {3'b101, ifc.oRom_addr};
  always @(negedge clk) if (ifc.oFrame_latch) pulses++;
  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic run_pix(input logic [9:0] x, input logic [8:0] y, input logic r,
                         output logic [12:0] a, output logic [15:0] c, output logic v);
    @(negedge clk);
    ifc.iVGA_X = x;
    ifc.iVGA_Y = y;
    ifc.iVGA_req = r;
    @(posedge clk);
    #1 a = ifc.oRom_addr;
    @(posedge clk);
    #1 c = ifc.oPix_color;
    v = ifc.oPix_valid;
  endtask
  task automatic pix(input string tag, input logic [9:0] x, input logic [8:0] y,
                     input logic [12:0] ea, input logic [15:0] ec);
    logic [12:0] a;
    logic [15:0] c;
    logic v;
    run_pix(x, y, 1'b1, a, c, v);
    check({tag, "_addr"}, 32'(a), 32'(ea));
    check({tag, "_color"}, 32'(c), 32'(ec));
    check({tag, "_valid"}, 32'(v), 32'd1);
  endtask
  function automatic logic [15:0] tex(input logic [12:0] a);
    return {3'b101, a};
  endfunction
  task automatic frame_start();
    @(negedge clk);
    ifc.iVGA_X = 10'd0;
    ifc.iVGA_Y = 9'd0;
    ifc.iVGA_req = 1'b1;
    repeat (3) @(negedge clk);
    exp_pulses++;
  endtask
  logic [12:0] a;
  logic [15:0] c;
  logic v;
  initial begin
    ifc.iVGA_X = 10'd5;
    ifc.iVGA_Y = 9'd5;
    ifc.iVGA_req = 1'b0;
    ifc.dancer_en = 4'b0000;
    {ifc.id0_x, ifc.id1_x, ifc.id2_x, ifc.ibruce_x} = '0;
    {ifc.id0_y, ifc.id1_y, ifc.id2_y, ifc.ibruce_y} = '0;
    ifc.iBg_color = BG;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(ifc.oPix_valid), 32'd0);
    check("rst_color", 32'(ifc.oPix_color), 32'd0);
    check("rst_addr", 32'(ifc.oRom_addr), 32'd0);
    check("rst_latch", 32'(ifc.oFrame_latch), 32'd0);
    check("rst_coll", 32'(ifc.oCollision), 32'd0);
    reset_n = 1'b1;
    // bruce at (100,50): origin and edges
    ifc.ibruce_x = 10'd100;
    ifc.ibruce_y = 9'd50;
    ifc.dancer_en = 4'b1000;
    frame_start();
    pix("t1_origin", 10'd100, 9'd50, 13'h1800, tex(13'h1800));
    pix("t2_dx31", 10'd131, 9'd50, 13'h181F, tex(13'h181F));
    pix("t2_dx32", 10'd132, 9'd50, 13'h0000, BG);
    pix("t2_left", 10'd99, 9'd50, 13'h0000, BG);
    pix("t2_dy63", 10'd100, 9'd113, 13'h1FE0, tex(13'h1FE0));
    pix("t2_dy64", 10'd100, 9'd114, 13'h0000, BG);
    // priority and transparency
    ifc.id0_x = 10'd200;
    ifc.id0_y = 9'd200;
    ifc.ibruce_x = 10'd190;
    ifc.ibruce_y = 9'd190;
    ifc.dancer_en = 4'b1001;
    frame_start();
    key_mode = 1'b1;
    pix("t3_key", 10'd200, 9'd200, 13'h194A, BG);
    key_mode = 1'b0;
    pix("t3_bruce", 10'd200, 9'd200, 13'h194A, tex(13'h194A));
    ifc.id1_x = 10'd195;
    ifc.id1_y = 9'd195;
    ifc.dancer_en = 4'b0011;
    frame_start();
    pix("t3_d0_over_d1", 10'd200, 9'd200, 13'h0000, tex(13'h0000));
    pix("t3_d1_only", 10'd196, 9'd196, 13'h0821, tex(13'h0821));
    // mid-frame move is deferred to the next frame
    ifc.ibruce_x = 10'd10;
    ifc.ibruce_y = 9'd10;
    ifc.dancer_en = 4'b1000;
    frame_start();
    pix("t4_old_a", 10'd15, 9'd15, 13'h18A5, tex(13'h18A5));
    ifc.ibruce_x = 10'd20;
    ifc.ibruce_y = 9'd20;
    pix("t4_row240", 10'd15, 9'd240, 13'h0000, BG);
    pix("t4_old_b", 10'd15, 9'd15, 13'h18A5, tex(13'h18A5));
    pix("t4_old_c", 10'd25, 9'd25, 13'h19EF, tex(13'h19EF));
    frame_start();
    pix("t4_new_a", 10'd15, 9'd15, 13'h0000, BG);
    pix("t4_new_b", 10'd25, 9'd25, 13'h18A5, tex(13'h18A5));
    // clipping at the screen edge
    ifc.id2_x = 10'd620;
    ifc.id2_y = 9'd470;
    ifc.dancer_en = 4'b0100;
    frame_start();
    pix("t5_corner", 10'd620, 9'd470, 13'h1000, tex(13'h1000));
    pix("t5_last", 10'd639, 9'd479, 13'h1133, tex(13'h1133));
    pix("t5_x640", 10'd640, 9'd470, 13'h0000, BG);
    pix("t5_wrap_y", 10'd630, 9'd0, 13'h0000, BG);
    pix("t5_origin", 10'd0, 9'd0, 13'h0000, BG);
    exp_pulses++;
    run_pix(10'd620, 9'd470, 1'b0, a, c, v);
    check("idle_valid", 32'(v), 32'd0);
    check("idle_color", 32'(c), 32'd0);
    check("latch_pulses", 32'(pulses), 32'(exp_pulses));
    // reset mid-line flushes pipeline and shadows
    run_pix(10'd620, 9'd470, 1'b1, a, c, v);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ifc.oPix_valid), 32'd0);
    check("mid_rst_addr", 32'(ifc.oRom_addr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pix("post_rst", 10'd620, 9'd470, 13'h0000, BG);
`ifdef COLLISION_EN
    ifc.id0_x = 10'd300;
    ifc.id0_y = 9'd300;
    ifc.id1_x = 10'd310;
    ifc.id1_y = 9'd300;
    ifc.dancer_en = 4'b0011;
    frame_start();
    pix("t6_overlap", 10'd315, 9'd305, 13'h00AF, tex(13'h00AF));
    frame_start();
    check("t6_coll_set", 32'(ifc.oCollision), 32'd1);
    pix("t6_single", 10'd300, 9'd300, 13'h0000, tex(13'h0000));
    frame_start();
    check("t6_coll_clr", 32'(ifc.oCollision), 32'd0);
`else
    check("coll_tied", 32'(ifc.oCollision), 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
